// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module   : des_pkg
// Purpose  : Shared DES constants and helpers for the iterative DES controller:
//            key-shift schedule, FSM state enum, IP / IP^-1 / PC1 / PC2 / P
//            index tables, S-box contents, and permutation helper functions.
//            Bit numbering follows DES: vectors are declared [1:N] and
//            bit 1 is the MSB.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package des_pkg;

  // Round counter width; holds 0..NUM_ROUNDS+1 without wrapping.
  localparam int RND_W = 5;

  // Left-rotate amount per round for the C/D key halves.
  localparam logic [1:0] SHIFT [1:16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } des_state_t;

  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int IPI_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
  };

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
  };

  // One 256-bit word per S-box; entry (row*16 + col) sits at nibble
  // position counted from the MSB.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
  };

  function automatic logic [1:64] ip_perm(input logic [1:64] d);
    logic [1:64] o;
    for (int i = 0; i < 64; i++) o[7'(i + 1)] = d[7'(IP_TAB[6'(i)])];
    return o;
  endfunction

  function automatic logic [1:64] ip_inv_perm(input logic [1:64] d);
    logic [1:64] o;
    for (int i = 0; i < 64; i++) o[7'(i + 1)] = d[7'(IPI_TAB[6'(i)])];
    return o;
  endfunction

  // Parity bits (8, 16, ..., 64) are never referenced by PC1.
  function automatic logic [1:56] pc1_perm(input logic [1:64] d);
    logic [1:56] o;
    for (int i = 0; i < 56; i++) o[6'(i + 1)] = d[7'(PC1_TAB[6'(i)])];
    return o;
  endfunction

  function automatic logic [1:48] pc2_perm(input logic [1:56] d);
    logic [1:48] o;
    for (int i = 0; i < 48; i++) o[6'(i + 1)] = d[6'(PC2_TAB[6'(i)])];
    return o;
  endfunction

  // E is regular: output group g copies R bits 4g..4g+5 (1-based, wrapping).
  function automatic logic [1:48] e_expand(input logic [1:32] r);
    logic [1:48] o;
    for (int j = 0; j < 48; j++)
      o[6'(j + 1)] = r[6'(((4 * (j / 6) + (j % 6) + 31) % 32) + 1)];
    return o;
  endfunction

  function automatic logic [1:32] p_perm(input logic [1:32] d);
    logic [1:32] o;
    for (int i = 0; i < 32; i++) o[6'(i + 1)] = d[6'(P_TAB[5'(i)])];
    return o;
  endfunction

  // Row = outer bits {b1,b6}, column = inner bits b2..b5.
  function automatic logic [3:0] sbox_lookup(input int n, input logic [5:0] x);
    logic [5:0]   idx;
    logic [255:0] word;
    idx  = {x[5], x[0], x[4:1]};
    word = SBOX[3'(n)] >> {6'd63 - idx, 2'b00};
    return word[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_iter_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : des_iter_controller_if
// Purpose  : Block-in / result-out valid-ready bundle for des_iter_controller.
//            slave  : controller side; master : source/sink side.
// Signals  : in_valid/in_ready/in_data/in_key/in_decrypt (input block),
//            out_valid/out_ready/out_data (result), busy (status),
//            blk_cnt (only with DES_BLOCK_CNT_EN defined).
// Revision : 1.0 - initial release
// ============================================================================
interface des_iter_controller_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:64] in_data;
  logic [1:64] in_key;
  logic        in_decrypt;
  logic        out_valid;
  logic        out_ready;
  logic [1:64] out_data;
  logic        busy;
`ifdef DES_BLOCK_CNT_EN
  logic [31:0] blk_cnt;
`endif

  modport slave (
    input  in_valid, in_data, in_key, in_decrypt, out_ready,
    output in_ready, out_valid, out_data, busy
`ifdef DES_BLOCK_CNT_EN
    , output blk_cnt
`endif
  );

  modport master (
    output in_valid, in_data, in_key, in_decrypt, out_ready,
    input  in_ready, out_valid, out_data, busy
`ifdef DES_BLOCK_CNT_EN
    , input blk_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/des_iter_controller_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : des_key_schedule
// Purpose  : Combinational on-the-fly DES subkey generator.
//            Encrypt: rotate C/D left first, subkey = PC2(rotated).
//            Decrypt: subkey = PC2(current), then rotate right using the
//            schedule run backwards, so round 1 yields K16 = PC2(PC1(key)).
// Ports    : i_cd      [1:56] registered C/D halves
//            i_rnd     [4:0]  current round (1..NUM_ROUNDS)
//            i_decrypt        direction
//            o_cd_next [1:56] C/D for the next round
//            o_subkey  [1:48] subkey for this round
// Revision : 1.0 - initial release
// ============================================================================
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic [1:56]      i_cd,
  input  logic [RND_W-1:0] i_rnd,
  input  logic             i_decrypt,
  output logic [1:56]      o_cd_next,
  output logic [1:48]      o_subkey
);

  logic [RND_W-1:0] w_sched_idx;
  logic             w_two;
  logic [1:28]      w_c;
  logic [1:28]      w_d;
  logic [1:28]      w_c_n;
  logic [1:28]      w_d_n;

  assign w_sched_idx = i_decrypt ? (RND_W'(NUM_ROUNDS + 1) - i_rnd) : i_rnd;
  assign w_two       = (SHIFT[w_sched_idx] == 2'd2);
  assign w_c         = i_cd[1:28];
  assign w_d         = i_cd[29:56];

  always_comb begin
    w_c_n    = w_c;
    w_d_n    = w_d;
    o_subkey = '0;
    if (i_decrypt) begin
      w_c_n    = w_two ? {w_c[27:28], w_c[1:26]} : {w_c[28], w_c[1:27]};
      w_d_n    = w_two ? {w_d[27:28], w_d[1:26]} : {w_d[28], w_d[1:27]};
      o_subkey = pc2_perm(i_cd);
    end else begin
      w_c_n    = w_two ? {w_c[3:28], w_c[1:2]} : {w_c[2:28], w_c[1]};
      w_d_n    = w_two ? {w_d[3:28], w_d[1:2]} : {w_d[2:28], w_d[1]};
      o_subkey = pc2_perm({w_c_n, w_d_n});
    end
  end

  assign o_cd_next = {w_c_n, w_d_n};

endmodule
`default_nettype wire

// File: rtl/des_round_core.sv
`default_nettype none
// ============================================================================
// Module   : des_round_core
// Purpose  : One combinational DES Feistel round: {L,R} -> {R, L ^ f(R,K)}.
// Ports    : i_lr     [1:64] current {L,R}
//            i_subkey [1:48] round subkey
//            o_lr     [1:64] swapped next {L,R}
// Revision : 1.0 - initial release
// ============================================================================
module des_round_core
  import des_pkg::*;
(
  input  logic [1:64] i_lr,
  input  logic [1:48] i_subkey,
  output logic [1:64] o_lr
);

  logic [1:32] w_r;
  logic [1:48] w_x;
  logic [1:32] w_s;

  assign w_r = i_lr[33:64];
  assign w_x = e_expand(w_r) ^ i_subkey;

  for (genvar b = 0; b < 8; b++) begin : g_sbox
    assign w_s[4*b+1 +: 4] = sbox_lookup(b, w_x[6*b+1 +: 6]);
  end

  assign o_lr = {w_r, i_lr[1:32] ^ p_perm(w_s)};

endmodule
`default_nettype wire

// File: rtl/des_iter_controller.sv
`default_nettype none
// ============================================================================
// Module   : des_iter_controller
// Purpose  : Iterative DES engine. One shared Feistel round is reused for
//            NUM_ROUNDS cycles per block; IP on load, swap + IP^-1 on finish.
//            Optional macro DES_BLOCK_CNT_EN adds a 32-bit completed-block
//            counter (bus.blk_cnt).
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - des_iter_controller_if.slave (in_* block source,
//                    out_* result sink, busy status)
// Latency  : out_valid rises NUM_ROUNDS+1 edges after the accept edge;
//            one block per NUM_ROUNDS+3 cycles with out_ready held high.
// Revision : 1.0 - initial release
// ============================================================================
module des_iter_controller
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  des_iter_controller_if.slave  bus
);

  des_state_t       r_state;
  des_state_t       w_state_next;
  logic [1:64]      r_lr;
  logic [1:56]      r_cd;
  logic             r_mode;
  logic [RND_W-1:0] r_rnd;
  logic [1:64]      r_out_data;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_busy;
  logic             w_accept;
  logic             w_out_hs;
  logic             w_last_round;
  logic [1:56]      w_cd_next;
  logic [1:48]      w_subkey;
  logic [1:64]      w_lr_next;

  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_out_hs     = r_out_valid && bus.out_ready;
  assign w_last_round = (r_rnd == RND_W'(NUM_ROUNDS));

  des_key_schedule #(
    .NUM_ROUNDS (NUM_ROUNDS)
  ) u_key_schedule (
    .i_cd      (r_cd),
    .i_rnd     (r_rnd),
    .i_decrypt (r_mode),
    .o_cd_next (w_cd_next),
    .o_subkey  (w_subkey)
  );

  des_round_core u_round_core (
    .i_lr     (r_lr),
    .i_subkey (w_subkey),
    .o_lr     (w_lr_next)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)     w_state_next = ROUND;
      ROUND:   if (w_last_round) w_state_next = FINAL;
      FINAL:                     w_state_next = DONE;
      DONE:    if (w_out_hs)     w_state_next = IDLE;
      default:                   w_state_next = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      IDLE:               w_in_ready = 1'b1;
      ROUND, FINAL, DONE: w_busy     = 1'b1;
      default:            w_in_ready = 1'b0;
    endcase
  end

  // Datapath: block/key load, one round per ROUND cycle, result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lr        <= '0;
      r_cd        <= '0;
      r_mode      <= 1'b0;
      r_rnd       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_lr   <= ip_perm(bus.in_data);
        r_cd   <= pc1_perm(bus.in_key);
        r_mode <= bus.in_decrypt;
        r_rnd  <= RND_W'(1);
      end else if (r_state == ROUND) begin
        r_lr  <= w_lr_next;
        r_cd  <= w_cd_next;
        r_rnd <= r_rnd + RND_W'(1);
      end

      // The last round already swapped halves; {R16,L16} undoes that.
      if (r_state == FINAL) begin
        r_out_data  <= ip_inv_perm({r_lr[33:64], r_lr[1:32]});
        r_out_valid <= 1'b1;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef DES_BLOCK_CNT_EN
  logic [31:0] r_blk_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_blk_cnt <= '0;
    else if (w_out_hs) r_blk_cnt <= r_blk_cnt + 32'd1;
  end

  assign bus.blk_cnt = r_blk_cnt;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_des_iter_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_iter_controller
// Purpose  : Directed self-checking bench for des_iter_controller using
//            published DES vectors. Define DES_BLOCK_CNT_EN to also exercise
//            the block counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_iter_controller;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P2 = 64'h8787878787878787;
  localparam logic [63:0] C2 = 64'h0000000000000000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  des_iter_controller_if bus ();

  des_iter_controller #(
    .NUM_ROUNDS (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one block for exactly one edge (caller ensures in_ready is high).
  task automatic send_block(input logic [63:0] key, input logic [63:0] data, input logic dec);
    bus.in_key     = key;
    bus.in_data    = data;
    bus.in_decrypt = dec;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid   = 1'b0;
  endtask

  // Counts edges until out_valid; tallies in_ready/busy violations meanwhile.
  task automatic wait_out(output int lat, output int ready_bad, output int busy_bad);
    lat = 0; ready_bad = 0; busy_bad = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      if (bus.in_ready !== 1'b0) ready_bad++;
      if (bus.busy !== 1'b1) busy_bad++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data got %h expected 0", bus.out_data); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got in_ready=%b busy=%b expected 1/0", bus.in_ready, bus.busy); end
  endtask

  task automatic test_single_block(input logic [63:0] key, input logic [63:0] data, input logic dec,
                                   input logic [63:0] exp, input string name);
    int lat, rb, bb;
    bus.out_ready = 1'b1;
    send_block(key, data, dec);
    wait_out(lat, rb, bb);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL %s_latency got %0d expected 17", name, lat); end
    n_checks++; if (bus.out_data !== exp) begin n_fail++; $display("FAIL %s_data got %h expected %h", name, bus.out_data, exp); end
    n_checks++; if (rb !== 0) begin n_fail++; $display("FAIL %s_in_ready_busy got %0d cycles with in_ready!=0 expected 0", name, rb); end
    n_checks++; if (bb !== 0) begin n_fail++; $display("FAIL %s_busy got %0d cycles with busy!=1 expected 0", name, bb); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_handshake got out_valid=%b in_ready=%b expected 0/1", name, bus.out_valid, bus.in_ready); end
    n_checks++; if (bus.out_data !== exp) begin n_fail++; $display("FAIL %s_data_hold got %h expected %h", name, bus.out_data, exp); end
  endtask

  task automatic test_backpressure();
    int lat, rb, bb, stable_bad;
    bus.out_ready = 1'b0;
    send_block(K1, P1, 1'b0);
    wait_out(lat, rb, bb);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL bp_latency got %0d expected 17", lat); end
    // A competing block is offered during the stall and must not be taken.
    bus.in_key = K2; bus.in_data = P2; bus.in_decrypt = 1'b0; bus.in_valid = 1'b1;
    stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out_data !== C1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) stable_bad++;
      tick();
    end
    n_checks++; if (stable_bad !== 0) begin n_fail++; $display("FAIL bp_stall got %0d unstable cycles expected 0", stable_bad); end
    n_checks++; if (bus.out_data !== C1) begin n_fail++; $display("FAIL bp_data got %h expected %h", bus.out_data, C1); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] keys [3];
    logic [63:0] dats [3];
    logic        decs [3];
    logic [63:0] exps [3];
    int          acc  [3];
    int          idx_in, idx_out, cyc;
    logic        accept_now;
    keys = '{K1, K1, K2};
    dats = '{P1, C1, P2};
    decs = '{1'b0, 1'b1, 1'b0};
    exps = '{C1, P1, C2};
    acc  = '{0, 0, 0};
    idx_in = 0; idx_out = 0; cyc = 0;
    bus.out_ready  = 1'b1;
    bus.in_key     = keys[0];
    bus.in_data    = dats[0];
    bus.in_decrypt = decs[0];
    bus.in_valid   = 1'b1;
    while (idx_out < 3 && cyc < 200) begin
      accept_now = bus.in_ready && bus.in_valid;
      if (bus.out_valid === 1'b1) begin
        n_checks++; if (bus.out_data !== exps[idx_out]) begin n_fail++; $display("FAIL b2b_data%0d got %h expected %h", idx_out, bus.out_data, exps[idx_out]); end
        idx_out++;
      end
      tick();
      cyc++;
      if (accept_now) begin
        acc[idx_in] = cyc;
        idx_in++;
        if (idx_in < 3) begin
          bus.in_key = keys[idx_in]; bus.in_data = dats[idx_in]; bus.in_decrypt = decs[idx_in];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid = 1'b0;
    n_checks++; if (idx_out !== 3) begin n_fail++; $display("FAIL b2b_count got %0d results expected 3", idx_out); end
    n_checks++; if (acc[1] - acc[0] !== 19) begin n_fail++; $display("FAIL b2b_spacing01 got %0d expected 19", acc[1] - acc[0]); end
    n_checks++; if (acc[2] - acc[1] !== 19) begin n_fail++; $display("FAIL b2b_spacing12 got %0d expected 19", acc[2] - acc[1]); end
    tick();
  endtask

  task automatic test_reset_mid_round();
    int bad;
    bus.out_ready = 1'b1;
    send_block(K2, P2, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b expected 1", bus.busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b expected 0", bus.busy); end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL midrst_no_partial got %0d valid cycles expected 0", bad); end
    test_single_block(K1, P1, 1'b0, C1, "midrst_next");
  endtask

`ifdef DES_BLOCK_CNT_EN
  task automatic test_blk_cnt();
    int lat, rb, bb;
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.blk_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_reset got %h expected 0", bus.blk_cnt); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_block(K1, P1, 1'b0);
      wait_out(lat, rb, bb);
      tick();
    end
    n_checks++; if (bus.blk_cnt !== 32'd5) begin n_fail++; $display("FAIL cnt_five got %h expected 5", bus.blk_cnt); end
    force dut.r_blk_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_blk_cnt;
    n_checks++; if (bus.blk_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cnt_forced got %h expected ffffffff", bus.blk_cnt); end
    send_block(K1, P1, 1'b0);
    wait_out(lat, rb, bb);
    tick();
    n_checks++; if (bus.blk_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_wrap got %h expected 0", bus.blk_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_key     = '0;
    bus.in_decrypt = 1'b0;
    bus.out_ready  = 1'b0;
    rst_n          = 1'b0;
    test_reset();
    test_single_block(K1, P1, 1'b0, C1, "enc_k1");
    test_single_block(K1, C1, 1'b1, P1, "dec_k1");
    test_single_block(K2, P2, 1'b0, C2, "enc_k2");
    test_single_block(K2, C2, 1'b1, P2, "dec_k2");
    test_backpressure();
    test_back_to_back();
    test_reset_mid_round();
`ifdef DES_BLOCK_CNT_EN
    test_blk_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
